bimodal_pred: RTL and testbench

Bimodal branch predictor for the pipelined core: a table of 2-bit saturating counters indexed by PC. Gives the IF stage a taken/not-taken prediction each cycle. When a branch resolves in EX, it compares the carried prediction with the actual outcome and updates the table. Produces the `EX_feedback_valid` / `EX_prediction_incorrect` pair consumed by the prediction performance counters.

---
 rtl/bimodal_pred.sv | 93 +++++++++
 tb/tb_bimodal_pred.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bimodal_pred.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by PC, with a
// one-entry pending-write register that delays table writes by one cycle.
module bimodal_pred #(
    parameter int          IDX_BITS = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_pc,
    output logic        IF_pred_taken,
    input  logic        EX_branch,
    input  logic        EX_stall,
    input  logic [31:0] EX_pc,
    input  logic        EX_pred_taken,
    input  logic        EX_taken,
    output logic        EX_feedback_valid,
    output logic        EX_prediction_incorrect
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          cnt_table [ENTRIES];
    logic                pend_v;
    logic [IDX_BITS-1:0] pend_idx;
    logic [1:0]          pend_cnt;

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic [1:0]          if_cnt;
    logic [1:0]          ex_cnt;
    logic [1:0]          next_cnt;
    logic                resolve;
    logic                unused_pc_bits;

    assign if_idx = IF_pc[IDX_BITS+1:2];
    assign ex_idx = EX_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{IF_pc[31:IDX_BITS+2], IF_pc[1:0],
                              EX_pc[31:IDX_BITS+2], EX_pc[1:0]};

    // Valid/ready does not apply here: a resolution is a single-cycle event
    // qualified by EX_branch and held off while EX is stalled.
    assign resolve                 = EX_branch & ~EX_stall;
    assign EX_feedback_valid       = resolve;
    assign EX_prediction_incorrect = resolve & (EX_pred_taken != EX_taken);

    // Both read ports see the pending write before it lands in the table.
    always_comb begin
        if_cnt = cnt_table[if_idx];
        if (pend_v && (pend_idx == if_idx)) begin
            if_cnt = pend_cnt;
        end
        ex_cnt = cnt_table[ex_idx];
        if (pend_v && (pend_idx == ex_idx)) begin
            ex_cnt = pend_cnt;
        end
    end

    assign IF_pred_taken = if_cnt[1];

    always_comb begin
        next_cnt = ex_cnt;
        if (EX_taken) begin
            if (ex_cnt != 2'b11) begin
                next_cnt = ex_cnt + 2'b01;
            end
        end else begin
            if (ex_cnt != 2'b00) begin
                next_cnt = ex_cnt - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_table[i] <= CNT_INIT;
            end
            pend_v   <= 1'b0;
            pend_idx <= '0;
            pend_cnt <= 2'b00;
        end else begin
            if (pend_v) begin
                cnt_table[pend_idx] <= pend_cnt;
            end
            pend_v <= resolve;
            if (resolve) begin
                pend_idx <= ex_idx;
                pend_cnt <= next_cnt;
            end
        end
    end

endmodule

// File: tb/tb_bimodal_pred.sv
// Directed bench for bimodal_pred: inputs driven on the falling edge,
// outputs checked 1ns later, well away from the rising edge.
module tb_bimodal_pred;

    logic        clk;
    logic        rst_n;
    logic [31:0] IF_pc;
    logic        IF_pred_taken;
    logic        EX_branch;
    logic        EX_stall;
    logic [31:0] EX_pc;
    logic        EX_pred_taken;
    logic        EX_taken;
    logic        EX_feedback_valid;
    logic        EX_prediction_incorrect;

    int tests_run;
    int tests_failed;

    bimodal_pred #(.IDX_BITS(6), .CNT_INIT(2'b01)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .IF_pc                   (IF_pc),
        .IF_pred_taken           (IF_pred_taken),
        .EX_branch               (EX_branch),
        .EX_stall                (EX_stall),
        .EX_pc                   (EX_pc),
        .EX_pred_taken           (EX_pred_taken),
        .EX_taken                (EX_taken),
        .EX_feedback_valid       (EX_feedback_valid),
        .EX_prediction_incorrect (EX_prediction_incorrect)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        EX_branch = 1'b0;
        EX_stall  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Driver: sets EX inputs and IF_pc at a falling edge, then settles 1ns.
    task automatic drive(input logic [31:0] if_pc, input logic br, input logic stall,
                         input logic [31:0] ex_pc, input logic pred, input logic taken);
        @(negedge clk);
        IF_pc         = if_pc;
        EX_branch     = br;
        EX_stall      = stall;
        EX_pc         = ex_pc;
        EX_pred_taken = pred;
        EX_taken      = taken;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            IF_pc = 32'(i) << 2;
            #1;
            tests_run++;
            if (IF_pred_taken !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_pred idx=%0d got=%b exp=0", i, IF_pred_taken);
            end
        end
        tests_run++;
        if (EX_feedback_valid !== 1'b0 || EX_prediction_incorrect !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_feedback got=%b%b exp=00", EX_feedback_valid, EX_prediction_incorrect);
        end
    endtask

    task automatic test_mispredict();
        apply_reset();
        drive(32'h104, 1'b1, 1'b0, 32'h104, 1'b0, 1'b1);
        tests_run++;
        if (EX_feedback_valid !== 1'b1 || EX_prediction_incorrect !== 1'b1 || IF_pred_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL mispredict_t got fv=%b pi=%b pred=%b exp fv=1 pi=1 pred=0",
                     EX_feedback_valid, EX_prediction_incorrect, IF_pred_taken);
        end
        for (int c = 1; c <= 3; c++) begin
            drive(32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            tests_run++;
            if (IF_pred_taken !== 1'b1 || EX_feedback_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL mispredict_t+%0d got pred=%b fv=%b exp pred=1 fv=0",
                         c, IF_pred_taken, EX_feedback_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_pred [5];
        logic [1:0] exp_pi   [5];
        logic       taken_v  [5];
        logic       pred_v   [5];
        // counter 01->10->11->11 (taken x3), then 11->10, 10->01 (not taken x2)
        taken_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        pred_v   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_pred = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        exp_pi   = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive(32'h104, 1'b1, 1'b0, 32'h104, pred_v[k], taken_v[k]);
            tests_run++;
            if (IF_pred_taken !== exp_pred[k][0] || EX_feedback_valid !== 1'b1 ||
                EX_prediction_incorrect !== exp_pi[k][0]) begin
                tests_failed++;
                $display("FAIL sat_step%0d got pred=%b fv=%b pi=%b exp pred=%b fv=1 pi=%b",
                         k, IF_pred_taken, EX_feedback_valid, EX_prediction_incorrect,
                         exp_pred[k][0], exp_pi[k][0]);
            end
        end
        for (int c = 1; c <= 2; c++) begin
            drive(32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            tests_run++;
            if (IF_pred_taken !== 1'b0) begin
                tests_failed++;
                $display("FAIL sat_after%0d got pred=%b exp=0", c, IF_pred_taken);
            end
        end
        // Different indices in consecutive cycles: idx3 taken, then idx4 down and up.
        drive(32'h10C, 1'b1, 1'b0, 32'h10C, 1'b0, 1'b1);
        drive(32'h10C, 1'b1, 1'b0, 32'h110, 1'b0, 1'b0);
        tests_run++;
        if (IF_pred_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idx3_bypass got pred=%b exp=1", IF_pred_taken);
        end
        drive(32'h10C, 1'b1, 1'b0, 32'h110, 1'b0, 1'b1);
        tests_run++;
        if (IF_pred_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idx3_table got pred=%b exp=1", IF_pred_taken);
        end
        drive(32'h110, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if (IF_pred_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idx4 got pred=%b exp=0", IF_pred_taken);
        end
    endtask

    task automatic test_stall();
        int pulses;
        apply_reset();
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            drive(32'h108, 1'b1, 1'b1, 32'h108, 1'b0, 1'b1);
            pulses += int'(EX_feedback_valid);
            tests_run++;
            if (EX_feedback_valid !== 1'b0 || EX_prediction_incorrect !== 1'b0 || IF_pred_taken !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_cycle%0d got fv=%b pi=%b pred=%b exp 0 0 0",
                         c, EX_feedback_valid, EX_prediction_incorrect, IF_pred_taken);
            end
        end
        drive(32'h108, 1'b1, 1'b0, 32'h108, 1'b0, 1'b1);
        pulses += int'(EX_feedback_valid);
        tests_run++;
        if (EX_feedback_valid !== 1'b1 || EX_prediction_incorrect !== 1'b1 || pulses != 1) begin
            tests_failed++;
            $display("FAIL stall_release got fv=%b pi=%b pulses=%0d exp fv=1 pi=1 pulses=1",
                     EX_feedback_valid, EX_prediction_incorrect, pulses);
        end
        drive(32'h108, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if (IF_pred_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_pred got pred=%b exp=1", IF_pred_taken);
        end
        // One not-taken: a single update left 10 -> 01 (predict 0).
        drive(32'h108, 1'b1, 1'b0, 32'h108, 1'b1, 1'b0);
        drive(32'h108, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if (IF_pred_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_single_update got pred=%b exp=0", IF_pred_taken);
        end
    endtask

    task automatic test_aliasing();
        apply_reset();
        drive(32'h200, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1);
        drive(32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if (IF_pred_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL alias_0x200 got pred=%b exp=1", IF_pred_taken);
        end
        IF_pc = 32'h104;
        #1;
        tests_run++;
        if (IF_pred_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL alias_0x104 got pred=%b exp=0", IF_pred_taken);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(32'h104, 1'b1, 1'b0, 32'h104, 1'b0, 1'b1);
        @(negedge clk);
        rst_n         = 1'b0;
        EX_branch     = 1'b1;
        EX_pred_taken = 1'b1;
        EX_taken      = 1'b0;
        #1;
        tests_run++;
        if (IF_pred_taken !== 1'b0 || EX_feedback_valid !== 1'b1 || EX_prediction_incorrect !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_during got pred=%b fv=%b pi=%b exp pred=0 fv=1 pi=1",
                     IF_pred_taken, EX_feedback_valid, EX_prediction_incorrect);
        end
        EX_branch = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (IF_pred_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_release got pred=%b exp=0", IF_pred_taken);
        end
        for (int c = 1; c <= 2; c++) begin
            drive(32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            tests_run++;
            if (IF_pred_taken !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_after%0d got pred=%b exp=0", c, IF_pred_taken);
            end
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        IF_pc         = 32'h0;
        EX_branch     = 1'b0;
        EX_stall      = 1'b0;
        EX_pc         = 32'h0;
        EX_pred_taken = 1'b0;
        EX_taken      = 1'b0;
        test_reset();
        test_mispredict();
        test_back_to_back();
        test_stall();
        test_aliasing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
